// File: rtl/seq_mult_8x8_pkg.sv
// rtl/seq_mult_8x8_pkg.sv - shared width default and FSM state encoding for seq_mult_8x8
package seq_mult_8x8_pkg;

  localparam int SM_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_RUN    = 3'd3,
    ST_DONE   = 3'd4
  } sm_state_t;

endpackage

// File: rtl/seq_mult_8x8_mux2.sv
// rtl/seq_mult_8x8_mux2.sv - combinational 2:1 operand mux feeding the multiplier (sel=1 picks a)
module seq_mult_8x8_mux2 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sel,
  output logic [WIDTH-1:0] o_y
);

  assign o_y = i_sel ? i_a : i_b;

endmodule

// File: rtl/seq_mult_8x8_shift_add_step.sv
// rtl/seq_mult_8x8_shift_add_step.sv - one shift-add iteration with a carry-preserving upper add
module shift_add_step #(
  parameter int WIDTH = 8
) (
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_mcand,
  output logic [2*WIDTH-1:0] o_acc
);

  // Upper half plus multiplicand is kept WIDTH+1 bits wide so the carry
  // re-enters the accumulator on the shift instead of being lost.
  logic [WIDTH:0] w_sum;

  assign w_sum = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + {1'b0, i_mcand};

  // LSB of the accumulator is the current multiplier bit: add then shift, or shift only.
  assign o_acc = i_acc[0] ? {w_sum, i_acc[WIDTH-1:1]}
                          : {1'b0, i_acc[2*WIDTH-1:1]};

endmodule

// File: rtl/seq_mult_8x8.sv
// rtl/seq_mult_8x8.sv - sequential unsigned shift-add multiplier that drives its own operand mux select
module seq_mult_8x8
  import seq_mult_8x8_pkg::*;
#(
  parameter int WIDTH = SM_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   op_in,
  output logic               op_sel,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  sm_state_t          r_state;
  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_count;
  logic [2*WIDTH-1:0] r_product;
  logic               r_op_sel;
  logic               r_busy;
  logic               r_done;
  logic [2*WIDTH-1:0] w_acc_next;

  shift_add_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_acc   (r_acc),
    .i_mcand (r_mcand),
    .o_acc   (w_acc_next)
  );

  // Control FSM and datapath registers; outputs are registered against the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_mcand   <= '0;
      r_acc     <= '0;
      r_count   <= '0;
      r_product <= '0;
      r_op_sel  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state  <= ST_LOAD_A;
            r_op_sel <= 1'b1;
            r_busy   <= 1'b1;
          end
        end
        ST_LOAD_A: begin
          r_mcand  <= op_in;
          r_state  <= ST_LOAD_B;
          r_op_sel <= 1'b0;
        end
        ST_LOAD_B: begin
          r_acc   <= {{WIDTH{1'b0}}, op_in};
          r_count <= '0;
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          r_acc   <= w_acc_next;
          r_count <= r_count + CW'(1);
          if (r_count == LAST_ITER) begin
            r_product <= w_acc_next;
            r_state   <= ST_DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
          end
        end
        ST_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state  <= ST_LOAD_A;
            r_op_sel <= 1'b1;
            r_busy   <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_op_sel <= 1'b0;
          r_busy   <= 1'b0;
          r_done   <= 1'b0;
        end
      endcase
    end
  end

  assign op_sel  = r_op_sel;
  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

endmodule

// File: tb/tb_seq_mult_8x8.sv
// tb/tb_seq_mult_8x8.sv - self-checking bench for seq_mult_8x8 with operand mux in the loop
module tb_seq_mult_8x8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  a = 8'd0;
  logic [7:0]  b = 8'd0;
  logic [7:0]  w_op_in;
  logic        op_sel;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int n_tests = 0;
  int n_fail  = 0;
  int cycle   = 0;

  // Timeline model: m_t is the position within an operation (1 = first cycle
  // after the accepted start, 11 = done cycle, 0 = idle).
  int          m_t = 0;
  logic [7:0]  m_a = 8'd0;
  logic [7:0]  m_b = 8'd0;
  logic [15:0] m_prod = 16'd0;

  seq_mult_8x8_mux2 #(.WIDTH(8)) u_mux (
    .i_a   (a),
    .i_b   (b),
    .i_sel (op_sel),
    .o_y   (w_op_in)
  );

  seq_mult_8x8 #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op_in   (w_op_in),
    .op_sel  (op_sel),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cycle, got, exp);
    end
  endtask

  // Reference behaviour
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_t    = 0;
      m_a    = 8'd0;
      m_b    = 8'd0;
      m_prod = 16'd0;
    end else if (m_t == 0 || m_t == 11) begin
      m_t = start ? 1 : 0;
    end else begin
      if (m_t == 1) m_a = a;
      if (m_t == 2) m_b = b;
      if (m_t == 10) m_prod = 16'(m_a) * 16'(m_b);
      m_t++;
    end
  end

  // Per-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    cycle++;
    check("op_sel", 32'(op_sel), 32'(m_t == 1));
    check("busy", 32'(busy), 32'(m_t >= 1 && m_t <= 10));
    check("done", 32'(done), 32'(m_t == 11));
    check("product", 32'(product), 32'(m_prod));
    check("busy_done_excl", 32'(busy & done), 32'd0);
  end

  task automatic wait_done(input int start_cyc, output int lat);
    lat = start_cyc;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (done) break;
    end
  endtask

  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic [15:0] exp_p);
    int lat;
    @(negedge clk);
    a = ia;
    b = ib;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(0, lat);
    check("latency", 32'(lat), 32'd11);
    check("result", 32'(product), 32'(exp_p));
  endtask

  initial begin
    int lat;
    int n_done;
    repeat (3) @(negedge clk);
    check("rst_product", 32'(product), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_op_sel", 32'(op_sel), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_op(8'd13, 8'd11, 16'h008F);
    run_op(8'd255, 8'd255, 16'hFE01);
    run_op(8'd0, 8'd200, 16'h0000);
    run_op(8'd200, 8'd0, 16'h0000);
    run_op(8'd1, 8'd255, 16'h00FF);

    // Start held during RUN is ignored; start in the DONE cycle chains the next op
    @(negedge clk);
    a = 8'd6; b = 8'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    a = 8'd9; b = 8'd9; start = 1'b1;
    wait_done(3, lat);
    check("b2b_latency1", 32'(lat), 32'd11);
    check("b2b_result1", 32'(product), 32'd42);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(0, lat);
    check("b2b_latency2", 32'(lat), 32'd11);
    check("b2b_result2", 32'(product), 32'd81);

    // Asynchronous reset in the middle of RUN
    @(negedge clk);
    a = 8'd100; b = 8'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_product", 32'(product), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("midrst_no_done", 32'(n_done), 32'd0);
    run_op(8'd100, 8'd3, 16'h012C);

    for (int i = 0; i < 1000; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      run_op(ra, rb, 16'(ra) * 16'(rb));
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
